dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipelined core's MEM stage and a debug/DMA requester.
- Arbitrates each cycle with a starvation bound: core has priority, but debug is granted after STARVE_LIMIT consecutive lost cycles.
- Stalls the core when it loses arbitration.
- Returns debug read data registered, one cycle after grant.

Parameters:
- ADDR_W, 32, data address width
- XLEN, 32, data width
- STARVE_LIMIT, 4, consecutive cycles debug may lose to the core before forced grant (legal range 1..15)
- CNT_W, 16, width of the saturating conflict counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  core MEM stage performs a load or store this cycle
- c_we  in  1  core store
- c_amp  in  4  core byte enables
- c_addr  in  ADDR_W  core address
- c_wdata  in  XLEN  core store data
- c_rdata  out  XLEN  core load data, combinational
- c_stall  out  1  core must hold MEM stage and everything upstream
- d_req  in  1  debug request; held until granted
- d_we  in  1  debug write
- d_amp  in  4  debug byte enables
- d_addr  in  ADDR_W  debug address
- d_wdata  in  XLEN  debug write data
- d_gnt  out  1  debug request accepted this cycle
- d_rvalid  out  1  one-cycle response pulse
- d_rdata  out  XLEN  registered debug read data
- m_we  out  1  memory write enable
- m_amp  out  4  memory byte enables
- m_addr  out  ADDR_W  memory address
- m_wdata  out  XLEN  memory write data
- m_rdata  in  XLEN  memory read data (combinational read)
- conflicts  out  CNT_W  count of cycles where c_req and d_req were both asserted

Behaviour:
- Memory model: synchronous write at clk, combinational read.
- Grant rule, combinational in-cycle:
  - d_gnt = d_req & (~c_req | streak >= STARVE_LIMIT).
  - Core is granted when c_req & ~d_gnt.
- c_stall = c_req & d_gnt.
- Memory mux:
  - Debug granted: m_* driven from d_*.
  - Core granted: m_* driven from c_*.
  - Neither granted: m_we=0, m_amp=0, m_addr=0, m_wdata=0.
- c_rdata = m_rdata at all times. It is meaningful only when c_req & ~c_stall.
- streak (4-bit register) updates at clk:
  - cleared when d_gnt=1 or d_req=0;
  - incremented when d_req & c_req & ~d_gnt;
  - saturates at 15.
- Response register: on any d_gnt, next cycle d_rvalid=1.
  - Read (d_we=0): d_rdata = m_rdata sampled in the grant cycle.
  - Write: d_rdata = 0.
  - Otherwise d_rvalid=0 and d_rdata holds its last value.
- Back-to-back debug grants are legal. d_rvalid stays high across consecutive cycles, one pulse per grant.
- conflicts increments when c_req & d_req; saturates at all-ones.
- Reset (reset=0, asynchronous): streak=0, d_rvalid=0, d_rdata=0, conflicts=0.
  - Combinational outputs follow the inputs under the grant rule with streak=0.
  - A grant issued in the cycle reset asserts yields no d_rvalid.
- Debug changing d_addr/d_we while d_req=1 and not yet granted is legal. Fields are sampled only in the grant cycle.
- No alignment checks; amp is passed through unmodified.

Test Plan:
- Core only: c_req=1, c_we=1, c_amp=4'hF, c_addr=0x10, c_wdata=0xDEADBEEF; then load from 0x10. Required: c_stall=0, m_we=1 in the store cycle, c_rdata=0xDEADBEEF on the load, d_gnt=0.
- Debug only: d_req=1, d_we=0, d_addr=0x10. Required: d_gnt=1 in the same cycle; next cycle d_rvalid=1, d_rdata=0xDEADBEEF; then d_rvalid=0.
- Starvation bound: c_req=1 and d_req=1 held continuously, STARVE_LIMIT=4.
  - Required: core granted cycles 0–3 (c_stall=0); cycle 4 d_gnt=1, c_stall=1.
  - Cycle 5: core granted again, d_rvalid=1.
  - conflicts = 6 after 6 overlapping cycles.
- Debug byte write: d_we=1, d_amp=4'b0010, d_wdata=0x0000AB00 to 0x10, then core load 0x10. Required: c_rdata=0xDEADABEF; d_rvalid=1 with d_rdata=0 after the write.
- Reset mid-response: grant a debug read, assert reset=0 before the next edge. Required: d_rvalid=0, d_rdata=0, conflicts=0, streak=0 immediately; no response pulse after release.
- Idle: c_req=0, d_req=0. Required: m_we=0, m_amp=0, m_addr=0, c_stall=0, d_gnt=0, streak cleared.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: core MEM-stage port, debug/DMA port,
// the shared data-memory port and the conflict counter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CNT_W  = 16
);
    // core side
    logic              c_req;
    logic              c_we;
    logic [3:0]        c_amp;
    logic [ADDR_W-1:0] c_addr;
    logic [XLEN-1:0]   c_wdata;
    logic [XLEN-1:0]   c_rdata;
    logic              c_stall;
    // debug side
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_amp;
    logic [ADDR_W-1:0] d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [XLEN-1:0]   d_rdata;
    // memory side
    logic              m_we;
    logic [3:0]        m_amp;
    logic [ADDR_W-1:0] m_addr;
    logic [XLEN-1:0]   m_wdata;
    logic [XLEN-1:0]   m_rdata;
    // status
    logic [CNT_W-1:0]  conflicts;

    // requesters and memory model
    modport master (
        output c_req, c_we, c_amp, c_addr, c_wdata,
        output d_req, d_we, d_amp, d_addr, d_wdata,
        output m_rdata,
        input  c_rdata, c_stall, d_gnt, d_rvalid, d_rdata,
        input  m_we, m_amp, m_addr, m_wdata, conflicts
    );

    // arbiter
    modport slave (
        input  c_req, c_we, c_amp, c_addr, c_wdata,
        input  d_req, d_we, d_amp, d_addr, d_wdata,
        input  m_rdata,
        output c_rdata, c_stall, d_gnt, d_rvalid, d_rdata,
        output m_we, m_amp, m_addr, m_wdata, conflicts
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the core MEM stage has priority, the debug/DMA
// requester is forced through after STARVE_LIMIT consecutive lost cycles.
// Debug read data is returned registered one cycle after its grant.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    logic [3:0]       streak_q, streak_d;
    logic             rvalid_q, rvalid_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic [CNT_W-1:0] conflicts_q, conflicts_d;

    logic d_gnt;
    logic c_gnt;
    logic starved;

    assign starved = (streak_q >= 4'(STARVE_LIMIT));

    // Grant decision and memory-port mux (idle port drives all zeros)
    always_comb begin
        d_gnt       = bus.d_req & (~bus.c_req | starved);
        c_gnt       = bus.c_req & ~d_gnt;
        bus.m_we    = 1'b0;
        bus.m_amp   = 4'b0000;
        bus.m_addr  = {ADDR_W{1'b0}};
        bus.m_wdata = '0;
        if (d_gnt) begin
            bus.m_we    = bus.d_we;
            bus.m_amp   = bus.d_amp;
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
        end else if (c_gnt) begin
            bus.m_we    = bus.c_we;
            bus.m_amp   = bus.c_amp;
            bus.m_addr  = bus.c_addr;
            bus.m_wdata = bus.c_wdata;
        end
    end

    assign bus.d_gnt     = d_gnt;
    assign bus.c_stall   = bus.c_req & d_gnt;
    assign bus.c_rdata   = bus.m_rdata;
    assign bus.d_rvalid  = rvalid_q;
    assign bus.d_rdata   = rdata_q;
    assign bus.conflicts = conflicts_q;

    // Next-state for starvation streak, debug response and conflict counter
    always_comb begin
        streak_d    = streak_q;
        rvalid_d    = d_gnt;
        rdata_d     = rdata_q;
        conflicts_d = conflicts_q;

        if (!bus.d_req || d_gnt) begin
            streak_d = 4'd0;
        end else if (bus.c_req && streak_q != 4'hF) begin
            streak_d = streak_q + 4'd1;
        end

        if (d_gnt) begin
            rdata_d = bus.d_we ? '0 : bus.m_rdata;
        end

        if (bus.c_req && bus.d_req && conflicts_q != '1) begin
            conflicts_d = conflicts_q + 1'b1;
        end
    end

    // State registers, cleared asynchronously so a grant in the reset cycle leaves no response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q    <= 4'd0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            conflicts_q <= '0;
        end else begin
            streak_q    <= streak_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            conflicts_q <= conflicts_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a small byte-enabled memory.
module tb_dmem_arbiter;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.ADDR_W(32), .XLEN(32), .CNT_W(16)) bus ();

    dmem_arbiter #(
        .ADDR_W(32),
        .XLEN(32),
        .STARVE_LIMIT(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory: synchronous byte-enabled write, combinational read
    logic [31:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (bus.m_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.m_amp[b]) mem[bus.m_addr[7:2]][b*8 +: 8] <= bus.m_wdata[b*8 +: 8];
        end
    end
    assign bus.m_rdata = mem[bus.m_addr[7:2]];

    typedef struct {
        string       name;
        logic        gnt;
        logic        stall;
        logic        mwe;
        logic [3:0]  mamp;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        rvalid;
        bit          chk_crd;
        logic [31:0] crd;
        bit          chk_conf;
        logic [15:0] conf;
        bit          chk_drd;
        logic [31:0] drd;
    } cyc_t;

    cyc_t        cyc_q [$];
    logic [31:0] rsp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    event        chk_ev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic cyc_t mk(input string nm, input logic gnt, input logic stall,
                                input logic mwe, input logic [3:0] mamp,
                                input logic [31:0] maddr, input logic [31:0] mwdata,
                                input logic rvalid, input logic [15:0] conf);
        cyc_t r;
        r.name = nm; r.gnt = gnt; r.stall = stall; r.mwe = mwe; r.mamp = mamp;
        r.maddr = maddr; r.mwdata = mwdata; r.rvalid = rvalid;
        r.chk_crd = 1'b0; r.crd = '0;
        r.chk_conf = 1'b1; r.conf = conf;
        r.chk_drd = 1'b0; r.drd = '0;
        return r;
    endfunction

    task automatic drive(input logic cr, input logic cw, input logic [3:0] ca,
                         input logic [31:0] cad, input logic [31:0] cwd,
                         input logic dr, input logic dw, input logic [3:0] da,
                         input logic [31:0] dad, input logic [31:0] dwd);
        bus.c_req = cr; bus.c_we = cw; bus.c_amp = ca; bus.c_addr = cad; bus.c_wdata = cwd;
        bus.d_req = dr; bus.d_we = dw; bus.d_amp = da; bus.d_addr = dad; bus.d_wdata = dwd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // monitor: checks one expectation per presented cycle, pops a response on each d_rvalid
    initial begin
        cyc_t r;
        forever begin
            @(negedge clk or chk_ev);
            while (cyc_q.size() > 0) begin
                r = cyc_q.pop_front();
                chk({r.name, ".d_gnt"},   32'(bus.d_gnt),   32'(r.gnt));
                chk({r.name, ".c_stall"}, 32'(bus.c_stall), 32'(r.stall));
                chk({r.name, ".m_we"},    32'(bus.m_we),    32'(r.mwe));
                chk({r.name, ".m_amp"},   32'(bus.m_amp),   32'(r.mamp));
                chk({r.name, ".m_addr"},  bus.m_addr,       r.maddr);
                chk({r.name, ".m_wdata"}, bus.m_wdata,      r.mwdata);
                chk({r.name, ".d_rvalid"}, 32'(bus.d_rvalid), 32'(r.rvalid));
                if (r.chk_crd)  chk({r.name, ".c_rdata"}, bus.c_rdata, r.crd);
                if (r.chk_conf) chk({r.name, ".conflicts"}, 32'(bus.conflicts), 32'(r.conf));
                if (r.chk_drd)  chk({r.name, ".d_rdata_hold"}, bus.d_rdata, r.drd);
                if (bus.d_rvalid === 1'b1) begin
                    if (rsp_q.size() == 0) begin
                        chk({r.name, ".rsp_unexpected"}, 32'(bus.d_rvalid), 32'h0);
                    end else begin
                        chk({r.name, ".d_rdata"}, bus.d_rdata, rsp_q.pop_front());
                    end
                end
            end
        end
    end

    // time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

    initial begin
        cyc_t r;
        reset = 1'b0;
        idle();
        r = mk("rst0", 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 16'd0);
        r.chk_drd = 1'b1; r.drd = 32'h0;
        cyc_q.push_back(r);
        next();
        cyc_q.push_back(mk("rst1", 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 16'd0));

        // core store then load
        next(); reset = 1'b1;
        drive(1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0, 32'h0);
        cyc_q.push_back(mk("cstore", 0, 0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 16'd0));
        next();
        drive(1, 0, 4'hF, 32'h10, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        r = mk("cload", 0, 0, 0, 4'hF, 32'h10, 32'h0, 0, 16'd0);
        r.chk_crd = 1'b1; r.crd = 32'hDEADBEEF;
        cyc_q.push_back(r);

        // debug read alone
        next();
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
        cyc_q.push_back(mk("dread", 1, 0, 0, 4'hF, 32'h10, 32'h0, 0, 16'd0));
        rsp_q.push_back(32'hDEADBEEF);
        next(); idle();
        cyc_q.push_back(mk("idle_a", 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 16'd0));
        next(); idle();
        cyc_q.push_back(mk("idle_b", 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 16'd0));

        // starvation bound: core wins 4 cycles, debug forced on the 5th
        for (int k = 0; k < 6; k++) begin
            next();
            drive(1, 0, 4'hF, 32'h20, 32'h0, 1, 0, 4'hF, 32'h10, 32'h12345678);
            if (k == 4) begin
                cyc_q.push_back(mk($sformatf("starve%0d", k), 1, 1, 0, 4'hF, 32'h10,
                                   32'h12345678, 0, 16'(k)));
                rsp_q.push_back(32'hDEADBEEF);
            end else begin
                r = mk($sformatf("starve%0d", k), 0, 0, 0, 4'hF, 32'h20, 32'h0,
                       (k == 5) ? 1'b1 : 1'b0, 16'(k));
                r.chk_crd = 1'b1; r.crd = 32'h0;
                cyc_q.push_back(r);
            end
        end
        next(); idle();
        cyc_q.push_back(mk("idle_c", 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 16'd6));

        // idle must have cleared the streak: again four full losses before the forced grant
        for (int k = 0; k < 5; k++) begin
            next();
            drive(1, 0, 4'hF, 32'h20, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
            if (k == 4) begin
                cyc_q.push_back(mk("restreak4", 1, 1, 0, 4'hF, 32'h10, 32'h0, 0, 16'd10));
                rsp_q.push_back(32'hDEADBEEF);
            end else begin
                cyc_q.push_back(mk($sformatf("restreak%0d", k), 0, 0, 0, 4'hF, 32'h20,
                                   32'h0, 0, 16'(6 + k)));
            end
        end
        next(); idle();
        cyc_q.push_back(mk("idle_d", 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 16'd11));

        // debug byte write, then core load sees merged word
        next();
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'b0010, 32'h10, 32'h0000AB00);
        cyc_q.push_back(mk("dwrite", 1, 0, 1, 4'b0010, 32'h10, 32'h0000AB00, 0, 16'd11));
        rsp_q.push_back(32'h0);
        next();
        drive(1, 0, 4'hF, 32'h10, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        r = mk("cload2", 0, 0, 0, 4'hF, 32'h10, 32'h0, 1, 16'd11);
        r.chk_crd = 1'b1; r.crd = 32'hDEADABEF;
        cyc_q.push_back(r);
        next(); idle();
        r = mk("idle_e", 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 16'd11);
        r.chk_drd = 1'b1; r.drd = 32'h0;
        cyc_q.push_back(r);

        // back-to-back debug reads
        next();
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0);
        cyc_q.push_back(mk("b2b0", 1, 0, 0, 4'hF, 32'h20, 32'h0, 0, 16'd11));
        rsp_q.push_back(32'h0);
        next();
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
        cyc_q.push_back(mk("b2b1", 1, 0, 0, 4'hF, 32'h10, 32'h0, 1, 16'd11));
        rsp_q.push_back(32'hDEADABEF);
        next(); idle();
        cyc_q.push_back(mk("idle_f", 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 16'd11));
        next(); idle();
        r = mk("idle_g", 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 16'd11);
        r.chk_drd = 1'b1; r.drd = 32'hDEADABEF;
        cyc_q.push_back(r);

        // build up streak and conflicts, grant a debug read, then reset before the next edge
        for (int k = 0; k < 4; k++) begin
            next();
            drive(1, 0, 4'hF, 32'h20, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
            cyc_q.push_back(mk($sformatf("prerst%0d", k), 0, 0, 0, 4'hF, 32'h20, 32'h0,
                               0, 16'(11 + k)));
        end
        next();
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
        cyc_q.push_back(mk("rstgnt", 1, 0, 0, 4'hF, 32'h10, 32'h0, 0, 16'd15));
        @(negedge clk);
        #1;
        reset = 1'b0;
        drive(1, 0, 4'hF, 32'h20, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
        #1;
        r = mk("rst_now", 0, 0, 0, 4'hF, 32'h20, 32'h0, 0, 16'd0);
        r.chk_drd = 1'b1; r.drd = 32'h0;
        cyc_q.push_back(r);
        ->chk_ev;
        next();
        r = mk("rst_hold", 0, 0, 0, 4'hF, 32'h20, 32'h0, 0, 16'd0);
        r.chk_drd = 1'b1; r.drd = 32'h0;
        cyc_q.push_back(r);
        next(); reset = 1'b1; idle();
        r = mk("rel0", 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 16'd0);
        r.chk_drd = 1'b1; r.drd = 32'h0;
        cyc_q.push_back(r);
        next(); idle();
        cyc_q.push_back(mk("rel1", 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 16'd0));

        next();
        @(negedge clk);
        #1;
        chk("rsp_drain", 32'(rsp_q.size()), 32'h0);
        chk("cyc_drain", 32'(cyc_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
